// File: rtl/rom_boot_sequencer_pkg.sv
// Shared definitions for the boot-ROM copy sequencer.
// Contents: the default bus widths, the sequencer state encoding and a small
// state-classification helper used by the top module.
package rom_boot_sequencer_pkg;

  localparam int unsigned DEF_ROM_AW = 8;
  localparam int unsigned DEF_DW     = 32;
  localparam int unsigned DEF_RAM_AW = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_LAT  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } boot_state_e;

  // True while a word is being moved from ROM to RAM.
  function automatic logic is_copy_state(input boot_state_e s);
    return (s == ST_RD) || (s == ST_LAT) || (s == ST_WR);
  endfunction

endpackage

// File: rtl/rom_boot_sequencer_if.sv
// Bus bundle around the boot sequencer.
//  host_* : read port from the TL-UL SRAM adapter (req/gnt, rvalid/rdata)
//  rom_*  : single-port boot ROM, data returned one cycle after rom_req
//  ram_*  : on-chip RAM write port, request held until ram_gnt
// Modport master is the sequencer side; slave is everything around it.
interface rom_boot_sequencer_if
  import rom_boot_sequencer_pkg::*;
#(
  parameter int unsigned ROM_AW = DEF_ROM_AW,
  parameter int unsigned DW     = DEF_DW,
  parameter int unsigned RAM_AW = DEF_RAM_AW
) ();

  logic              host_req;
  logic [ROM_AW-1:0] host_addr;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DW-1:0]     host_rdata;

  logic              rom_req;
  logic [ROM_AW-1:0] rom_addr;
  logic [DW-1:0]     rom_rdata;

  logic              ram_req;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [DW-1:0]     ram_wdata;
  logic [DW-1:0]     ram_wmask;
  logic              ram_gnt;

  modport master (
    input  host_req, host_addr, rom_rdata, ram_gnt,
    output host_gnt, host_rvalid, host_rdata,
    output rom_req, rom_addr,
    output ram_req, ram_we, ram_addr, ram_wdata, ram_wmask
  );

  modport slave (
    output host_req, host_addr, rom_rdata, ram_gnt,
    input  host_gnt, host_rvalid, host_rdata,
    input  rom_req, rom_addr,
    input  ram_req, ram_we, ram_addr, ram_wdata, ram_wmask
  );

endinterface

// File: rtl/rom_boot_sequencer.sv
// Boot sequencer between the ROM's TL-UL SRAM adapter and the boot ROM.
// After reset it copies COPY_WORDS ROM words to RAM (RAM_BASE onwards), then
// raises boot_done_o and gives the ROM port to the host. Host requests are
// stalled (never dropped) until then.
// Ports:
//  clk_i       clock
//  rst_i       asynchronous, active-high reset
//  start_i     re-run the copy; honoured only once the copy is done
//  bus         host/ROM/RAM bundle (master side)
//  busy_o      copy in progress
//  boot_done_o copy complete, ROM owned by the host
module rom_boot_sequencer
  import rom_boot_sequencer_pkg::*;
#(
  parameter int unsigned ROM_AW     = DEF_ROM_AW,
  parameter int unsigned DW         = DEF_DW,
  parameter int unsigned RAM_AW     = DEF_RAM_AW,
  parameter int unsigned COPY_WORDS = 256,
  parameter int unsigned RAM_BASE   = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  rom_boot_sequencer_if.master bus,
  output logic                busy_o,
  output logic                boot_done_o
);

  // One extra bit so COPY_WORDS == 2**ROM_AW reaches its last index without wrapping.
  localparam int unsigned      CNT_W    = ROM_AW + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COPY_WORDS - 1);

  boot_state_e       state_r, state_next_s;
  logic [CNT_W-1:0]  cnt_r, cnt_next_s;
  logic [DW-1:0]     wdata_r, wdata_next_s;
  logic              start_pend_r, start_pend_next_s;
  logic              rvalid_r;
  logic              busy_r;
  logic              done_r;
  logic              ram_req_r;
  logic              in_done_s;
  logic [RAM_AW-1:0] ram_addr_s;

  assign in_done_s  = (state_r == ST_DONE);
  assign ram_addr_s = RAM_AW'(RAM_BASE + 32'(cnt_r));

  // Next-state, word counter, captured data and deferred-start flag.
  always_comb begin
    state_next_s      = state_r;
    cnt_next_s        = cnt_r;
    wdata_next_s      = wdata_r;
    start_pend_next_s = start_pend_r;
    case (state_r)
      ST_IDLE: state_next_s = ST_RD;
      ST_RD:   state_next_s = ST_LAT;
      ST_LAT: begin
        wdata_next_s = bus.rom_rdata;
        state_next_s = ST_WR;
      end
      ST_WR: begin
        if (bus.ram_gnt) begin
          if (cnt_r == LAST_CNT) begin
            state_next_s = ST_DONE;
          end else begin
            cnt_next_s   = cnt_r + CNT_W'(1);
            state_next_s = ST_RD;
          end
        end else begin
          state_next_s = ST_WR;
        end
      end
      ST_DONE: begin
        // A restart waits until the host has no request and no read in flight.
        if ((start_i || start_pend_r) && !bus.host_req && !rvalid_r) begin
          cnt_next_s        = {CNT_W{1'b0}};
          start_pend_next_s = 1'b0;
          state_next_s      = ST_RD;
        end else if (start_i) begin
          start_pend_next_s = 1'b1;
        end else begin
          start_pend_next_s = start_pend_r;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // ROM port ownership: host in DONE, copy engine otherwise.
  always_comb begin
    if (in_done_s) begin
      bus.host_gnt   = bus.host_req;
      bus.rom_req    = bus.host_req;
      bus.rom_addr   = bus.host_addr;
      bus.host_rdata = bus.rom_rdata;
    end else begin
      bus.host_gnt   = 1'b0;
      bus.rom_req    = (state_r == ST_RD);
      bus.rom_addr   = cnt_r[ROM_AW-1:0];
      bus.host_rdata = {DW{1'b0}};
    end
  end

  // RAM write port is quiet (all zero) unless a write is being offered.
  always_comb begin
    bus.ram_req   = ram_req_r;
    bus.ram_we    = ram_req_r;
    bus.ram_wmask = {DW{ram_req_r}};
    if (ram_req_r) begin
      bus.ram_addr  = ram_addr_s;
      bus.ram_wdata = wdata_r;
    end else begin
      bus.ram_addr  = {RAM_AW{1'b0}};
      bus.ram_wdata = {DW{1'b0}};
    end
  end

  // Sequencer state, counter, data capture and pending start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      wdata_r      <= {DW{1'b0}};
      start_pend_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      cnt_r        <= cnt_next_s;
      wdata_r      <= wdata_next_s;
      start_pend_r <= start_pend_next_s;
    end
  end

  // Registered status outputs, decoded from the upcoming state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ram_req_r <= 1'b0;
      rvalid_r  <= 1'b0;
    end else begin
      busy_r    <= is_copy_state(state_next_s);
      done_r    <= (state_next_s == ST_DONE);
      ram_req_r <= (state_next_s == ST_WR);
      rvalid_r  <= bus.host_req & bus.host_gnt;
    end
  end

  assign bus.host_rvalid = rvalid_r;
  assign busy_o          = busy_r;
  assign boot_done_o     = done_r;

endmodule

// File: tb/tb_rom_boot_sequencer.sv
module tb_rom_boot_sequencer;

  localparam int ROM_AW = 8;
  localparam int DW     = 32;
  localparam int RAM_AW = 12;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst256, start, start256;
  logic busy4, done4, busy256, done256;

  rom_boot_sequencer_if #(.ROM_AW(ROM_AW), .DW(DW), .RAM_AW(RAM_AW)) b4 ();
  rom_boot_sequencer_if #(.ROM_AW(ROM_AW), .DW(DW), .RAM_AW(RAM_AW)) b256 ();

  rom_boot_sequencer #(.ROM_AW(ROM_AW), .DW(DW), .RAM_AW(RAM_AW), .COPY_WORDS(4), .RAM_BASE(0)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bus(b4.master),
    .busy_o(busy4), .boot_done_o(done4));

  rom_boot_sequencer #(.ROM_AW(ROM_AW), .DW(DW), .RAM_AW(RAM_AW), .COPY_WORDS(256), .RAM_BASE(0)) dut256 (
    .clk_i(clk), .rst_i(rst256), .start_i(start256), .bus(b256.master),
    .busy_o(busy256), .boot_done_o(done256));

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return 32'hA5A5_0000 + {24'h0, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ROM models: data one cycle after the chip select
  always @(posedge clk) if (b4.rom_req === 1'b1) b4.rom_rdata <= rom_word(b4.rom_addr);
  always @(posedge clk) if (b256.rom_req === 1'b1) b256.rom_rdata <= rom_word(b256.rom_addr);

  // ---------------- reference model + scoreboard (COPY_WORDS=4) ----------------
  wr_t         exp_wr_q[$];
  logic [31:0] exp_rd_q[$];
  bit          m_done, m_rvalid, m_pend, need_copy, hold_v;
  bit          nd, gnt_exp;
  wr_t         w;
  logic [11:0] hold_addr;
  logic [31:0] hold_data;

  task automatic push_copy();
    for (int i = 0; i < 4; i++) exp_wr_q.push_back({12'(i), rom_word(8'(i))});
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("reset_outputs", 64'({b4.ram_req, b4.rom_req, b4.host_gnt, b4.host_rvalid, done4, busy4,
                                  b4.ram_addr, b4.host_rdata}), 64'd0);
      exp_wr_q.delete();
      exp_rd_q.delete();
      m_done = 1'b0; m_rvalid = 1'b0; m_pend = 1'b0; need_copy = 1'b1; hold_v = 1'b0;
    end else begin
      if (need_copy) begin
        push_copy();
        need_copy = 1'b0;
      end
      nd = m_done;
      gnt_exp = b4.host_req & m_done;
      check("boot_done", 64'(done4), 64'(m_done));
      check("host_gnt", 64'(b4.host_gnt), 64'(gnt_exp));
      check("host_rvalid", 64'(b4.host_rvalid), 64'(m_rvalid));
      if (m_rvalid) begin
        if (exp_rd_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL host_rdata: no expected read queued");
        end else begin
          check("host_rdata", 64'(b4.host_rdata), 64'(exp_rd_q.pop_front()));
        end
      end else if (!m_done) begin
        check("host_rdata_idle", 64'(b4.host_rdata), 64'd0);
      end
      if (gnt_exp) exp_rd_q.push_back(rom_word(b4.host_addr));
      if (hold_v)
        check("ram_hold", 64'({b4.ram_req, b4.ram_addr, b4.ram_wdata}), 64'({1'b1, hold_addr, hold_data}));
      if (b4.ram_req) check("busy_in_wr", 64'(busy4), 64'd1);
      if (b4.ram_req && b4.ram_gnt) begin
        if (exp_wr_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL ram_write: unexpected write addr %h expected none", b4.ram_addr);
        end else begin
          w = exp_wr_q.pop_front();
          check("ram_write", 64'({b4.ram_we, b4.ram_addr, b4.ram_wdata}), 64'({1'b1, w.addr, w.data}));
          check("ram_wmask", 64'(b4.ram_wmask), 64'(32'hFFFF_FFFF));
          if (exp_wr_q.size() == 0) nd = 1'b1;
        end
      end
      hold_v    = b4.ram_req && !b4.ram_gnt;
      hold_addr = b4.ram_addr;
      hold_data = b4.ram_wdata;
      if (m_done) begin
        if ((start || m_pend) && !b4.host_req && !m_rvalid) begin
          push_copy();
          nd = 1'b0;
          m_pend = 1'b0;
        end else if (start) begin
          m_pend = 1'b1;
        end
      end
      m_rvalid = gnt_exp;
      m_done   = nd;
    end
  end

  // ---------------- full-size (256-word) write monitor ----------------
  int          idx256 = 0;
  logic [11:0] last256 = 12'd0;

  always @(negedge clk) begin
    if (!rst256 && b256.ram_req && b256.ram_gnt) begin
      check("w256", 64'({b256.ram_addr, b256.ram_wdata}), 64'({12'(idx256), rom_word(8'(idx256))}));
      last256 = b256.ram_addr;
      idx256++;
    end
  end

  // Run until boot_done_o, optionally stalling the grant on one word.
  task automatic run_copy(input int low_word, input int low_len, output int lat);
    int low_left;
    bit armed;
    lat = -1;
    low_left = 0;
    armed = (low_word >= 0);
    b4.ram_gnt = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk); #1;
      if (low_left > 0) begin
        low_left--;
        if (low_left == 0) b4.ram_gnt = 1'b1;
      end else if (armed && b4.ram_req && (int'(b4.ram_addr) == low_word)) begin
        b4.ram_gnt = 1'b0;
        low_left = low_len;
        armed = 1'b0;
      end
      if (done4) begin
        lat = cyc;
        break;
      end
    end
  endtask

  int lat;
  int n;

  initial begin
    rst = 1'b1; rst256 = 1'b1; start = 1'b0; start256 = 1'b0;
    b4.host_req = 1'b0; b4.host_addr = 8'd0; b4.ram_gnt = 1'b1;
    b256.host_req = 1'b0; b256.host_addr = 8'd0; b256.ram_gnt = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // plain copy, grant always high
    run_copy(-1, 0, lat);
    check("done_latency_gnt1", 64'(lat), 64'(13));
    repeat (20) begin
      @(posedge clk); #1;
      b4.host_req  = 1'($urandom_range(0, 1));
      b4.host_addr = 8'($urandom_range(0, 255));
    end

    // host read waiting during copy, 5 wait states on word 2
    @(posedge clk); #1;
    rst = 1'b1; b4.host_req = 1'b1; b4.host_addr = 8'd3;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_copy(2, 5, lat);
    check("done_latency_wait5", 64'(lat), 64'(18));
    repeat (3) @(posedge clk);

    // start pulse colliding with a host read
    #1 start = 1'b1; b4.host_req = 1'b1; b4.host_addr = 8'd7;
    @(posedge clk); #1;
    start = 1'b0; b4.host_req = 1'b0;
    n = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (!done4) begin
        n = c;
        break;
      end
    end
    check("restart_fall_cycles", 64'(n), 64'(2));
    run_copy(-1, 0, lat);
    check("restart_latency", 64'(lat), 64'(12));

    // reset while word 1 is waiting in the write phase
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n = -1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      if (b4.ram_req && b4.ram_addr == 12'd1) begin
        n = c;
        break;
      end
    end
    check("word1_wr_cycle", 64'(n), 64'(6));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_copy(-1, 0, lat);
    check("done_latency_after_rst", 64'(lat), 64'(13));

    // randomized traffic: grant stalls, host reads, start pulses
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      b4.ram_gnt   = ($urandom_range(0, 3) != 0);
      b4.host_req  = 1'($urandom_range(0, 1));
      b4.host_addr = 8'($urandom_range(0, 255));
      start        = ($urandom_range(0, 19) == 0);
    end
    @(posedge clk); #1;
    start = 1'b0; b4.host_req = 1'b0; b4.ram_gnt = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("final_done", 64'(done4), 64'd1);
    check("final_queue_empty", 64'(exp_wr_q.size()), 64'd0);

    // full 256-word copy with random grant stalls
    rst256 = 1'b0;
    n = -1;
    for (int c = 1; c <= 5000; c++) begin
      @(posedge clk); #1;
      b256.ram_gnt = ($urandom_range(0, 2) != 0);
      if (done256) begin
        n = c;
        break;
      end
    end
    check("done256_reached", 64'(n > 0), 64'd1);
    check("writes256", 64'(idx256), 64'(256));
    check("last_addr256", 64'(last256), 64'(255));
    repeat (5) @(posedge clk);
    #1;
    check("writes256_no_extra", 64'(idx256), 64'(256));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
